exception_handler_unit: RTL and testbench



---
 rtl/exception_handler_unit_pkg.sv | 30 +++
 rtl/exception_handler_unit_flush_timer.sv | 32 +++
 rtl/exception_handler_unit.sv | 153 +++++++++++++++
 tb/tb_exception_handler_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_handler_unit_pkg.sv
// Shared definitions for the exception path: FSM state encodings, the
// default handler vector and the return-address helper. The fetch-stage
// PC mux imports this package so both sides agree on the handler vector.
package exception_handler_unit_pkg;

  // Exception sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } state_e;

  // Fetch address of the exception handler unless overridden
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0100;

  // Width of the flush down-counter; holds FLUSH_CYCLES-1 for 1..15
  localparam int FLUSH_CNT_W = 4;

  // Returning from the handler skips the faulting instruction
  localparam logic [31:0] EPC_RETURN_OFFSET = 32'd4;

  // Resume address after the handler; wraps modulo 2^32
  function automatic logic [31:0] return_target(input logic [31:0] epcVal);
    return epcVal + EPC_RETURN_OFFSET;
  endfunction

endpackage

// File: rtl/exception_handler_unit_flush_timer.sv
// Loadable down-counter timing the pipeline flush phase. done_o is high
// whenever the count has reached zero, so the owner can leave the flush
// phase on the edge that sees it.
module flush_timer
  import exception_handler_unit_pkg::*;
#(
  parameter int W = FLUSH_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Load takes priority; otherwise count down while enabled, stopping at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/exception_handler_unit.sv
// Exception handler unit: accepts the illegal-opcode exception from decode,
// captures EPC and cause, flushes the pipeline for FLUSH_CYCLES cycles,
// redirects fetch to the handler, and on eret redirects back to EPC+4.
// A fault raised while the handler runs halts the core until reset.
// Every output comes straight from a flop; next-cycle output values are
// decoded from the next state so nothing combinational reaches a port.
module exception_handler_unit
  import exception_handler_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             excep_flag,
  input  logic [31:0]      ID_PC,
  input  logic [6:0]       ID_opcode,
  input  logic             eret,
  output logic             id_flush,
  output logic             EX_FLUSH,
  output logic             MEM_FLUSH,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [6:0]       cause,
  output logic             in_handler,
  output logic             halt_out,
  output logic [CNT_W-1:0] excep_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [6:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             idFlush_q, idFlush_d;
  logic             pipeFlush_q, pipeFlush_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirectPc_q, redirectPc_d;
  logic             inHandler_q, inHandler_d;
  logic             halt_q, halt_d;
  logic             timerLoad;
  logic             timerDone;

  flush_timer #(
    .W (FLUSH_CNT_W)
  ) u_flush_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timerLoad),
    .load_val_i (FLUSH_LOAD),
    .en_i       (state_q == ST_FLUSH),
    .done_o     (timerDone)
  );

  // Next-state, capture and registered-output decode for the exception sequencer
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    count_d   = count_q;
    timerLoad = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (excep_flag) begin
          epc_d     = ID_PC;
          cause_d   = ID_opcode;
          count_d   = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
          timerLoad = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (timerDone) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (eret) begin
          state_d = ST_RETURN;
        end else if (excep_flag) begin
          state_d = ST_HALT;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pipeFlush_d  = (state_d == ST_FLUSH);
    idFlush_d    = pipeFlush_d || (state_d == ST_RETURN);
    redirect_d   = (state_d == ST_REDIRECT) || (state_d == ST_RETURN);
    inHandler_d  = (state_d == ST_HANDLER);
    halt_d       = (state_d == ST_HALT);
    redirectPc_d = '0;
    if (state_d == ST_REDIRECT) begin
      redirectPc_d = HANDLER_ADDR;
    end else if (state_d == ST_RETURN) begin
      redirectPc_d = return_target(epc_d);
    end
  end

  // State, captured exception info and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      count_q      <= '0;
      idFlush_q    <= 1'b0;
      pipeFlush_q  <= 1'b0;
      redirect_q   <= 1'b0;
      redirectPc_q <= '0;
      inHandler_q  <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
      idFlush_q    <= idFlush_d;
      pipeFlush_q  <= pipeFlush_d;
      redirect_q   <= redirect_d;
      redirectPc_q <= redirectPc_d;
      inHandler_q  <= inHandler_d;
      halt_q       <= halt_d;
    end
  end

  assign id_flush    = idFlush_q;
  assign EX_FLUSH    = pipeFlush_q;
  assign MEM_FLUSH   = pipeFlush_q;
  assign pc_redirect = redirect_q;
  assign redirect_pc = redirectPc_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign in_handler  = inHandler_q;
  assign halt_out    = halt_q;
  assign excep_count = count_q;

endmodule

// File: tb/tb_exception_handler_unit.sv
// Directed self-checking bench for exception_handler_unit. Inputs change on
// the falling edge and outputs are sampled on the falling edge, half a cycle
// away from the posedge where the DUT updates. The DUT uses a 2-bit counter
// so saturation is reachable in a few round trips.
module tb_exception_handler_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        excep_flag;
  logic [31:0] ID_PC;
  logic [6:0]  ID_opcode;
  logic        eret;
  logic        id_flush;
  logic        EX_FLUSH;
  logic        MEM_FLUSH;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [6:0]  cause;
  logic        in_handler;
  logic        halt_out;
  logic [1:0]  excep_count;

  int checks   = 0;
  int failures = 0;

  exception_handler_unit #(
    .HANDLER_ADDR (32'h0000_0100),
    .FLUSH_CYCLES (2),
    .CNT_W        (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .excep_flag  (excep_flag),
    .ID_PC       (ID_PC),
    .ID_opcode   (ID_opcode),
    .eret        (eret),
    .id_flush    (id_flush),
    .EX_FLUSH    (EX_FLUSH),
    .MEM_FLUSH   (MEM_FLUSH),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .cause       (cause),
    .in_handler  (in_handler),
    .halt_out    (halt_out),
    .excep_count (excep_count)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Hold reset across two falling edges, release on a falling edge
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise one exception and wait until the handler is running
  task automatic enter_handler(input logic [31:0] pc, input logic [6:0] op);
    @(negedge clk);
    excep_flag = 1'b1;
    ID_PC      = pc;
    ID_opcode  = op;
    @(negedge clk);
    excep_flag = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    excep_flag = 1'b1;
    ID_PC      = 32'h0000_1234;
    ID_opcode  = 7'h11;
    @(negedge clk);
    excep_flag = 1'b0;
    checks++;
    if (id_flush !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_flush: got %b expected 1", id_flush);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect, redirect_pc, epc, cause,
         in_handler, halt_out, excep_count} !== 80'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: flush=%b%b%b redir=%b rpc=%h epc=%h cause=%h ih=%b halt=%b cnt=%0d expected all 0",
               id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect, redirect_pc, epc, cause, in_handler, halt_out, excep_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect, redirect_pc, in_handler, halt_out, excep_count} !== 40'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: flush=%b%b%b redir=%b rpc=%h ih=%b halt=%b cnt=%0d expected all 0",
               id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect, redirect_pc, in_handler, halt_out, excep_count);
    end
  endtask

  task automatic test_single_exception();
    do_reset();
    @(negedge clk);
    excep_flag = 1'b1;
    ID_PC      = 32'h0000_0040;
    ID_opcode  = 7'h7A;
    @(negedge clk);
    excep_flag = 1'b0;
    checks++;
    if ({id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL flush_cycle1: got %b%b%b redir=%b expected 111 redir=0", id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect);
    end
    @(negedge clk);
    checks++;
    if ({id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL flush_cycle2: got %b%b%b redir=%b expected 111 redir=0", id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect);
    end
    @(negedge clk);
    checks++;
    if ({id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect} !== 4'b0001 || redirect_pc !== 32'h0000_0100) begin
      failures++;
      $display("[TB] FAIL handler_redirect: flush=%b%b%b redir=%b rpc=%h expected 000 redir=1 rpc=00000100",
               id_flush, EX_FLUSH, MEM_FLUSH, pc_redirect, redirect_pc);
    end
    @(negedge clk);
    checks++;
    if (in_handler !== 1'b1 || pc_redirect !== 1'b0) begin
      failures++;
      $display("[TB] FAIL in_handler: ih=%b redir=%b expected ih=1 redir=0", in_handler, pc_redirect);
    end
    checks++;
    if (epc !== 32'h0000_0040 || cause !== 7'h7A || excep_count !== 2'd1) begin
      failures++;
      $display("[TB] FAIL captured_info: epc=%h cause=%h cnt=%0d expected epc=00000040 cause=7a cnt=1", epc, cause, excep_count);
    end
  endtask

  task automatic test_return();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    checks++;
    if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0000_0044 || id_flush !== 1'b1 ||
        EX_FLUSH !== 1'b0 || in_handler !== 1'b0) begin
      failures++;
      $display("[TB] FAIL return_redirect: redir=%b rpc=%h idf=%b exf=%b ih=%b expected redir=1 rpc=00000044 idf=1 exf=0 ih=0",
               pc_redirect, redirect_pc, id_flush, EX_FLUSH, in_handler);
    end
    @(negedge clk);
    checks++;
    if (pc_redirect !== 1'b0 || id_flush !== 1'b0 || in_handler !== 1'b0 ||
        epc !== 32'h0000_0040 || cause !== 7'h7A) begin
      failures++;
      $display("[TB] FAIL return_idle: redir=%b idf=%b ih=%b epc=%h cause=%h expected 0 0 0 00000040 7a",
               pc_redirect, id_flush, in_handler, epc, cause);
    end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_redirect !== 1'b0 || id_flush !== 1'b0 || in_handler !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eret_in_idle: redir=%b idf=%b ih=%b expected all 0", pc_redirect, id_flush, in_handler);
    end
  endtask

  task automatic test_nested_fault();
    enter_handler(32'h0000_0040, 7'h7A);
    excep_flag = 1'b1;
    ID_PC      = 32'h0000_DEAD;
    ID_opcode  = 7'h55;
    @(negedge clk);
    excep_flag = 1'b0;
    checks++;
    if (halt_out !== 1'b1 || in_handler !== 1'b0 || epc !== 32'h0000_0040 ||
        cause !== 7'h7A || excep_count !== 2'd2) begin
      failures++;
      $display("[TB] FAIL nested_halt: halt=%b ih=%b epc=%h cause=%h cnt=%0d expected 1 0 00000040 7a 2",
               halt_out, in_handler, epc, cause, excep_count);
    end
    eret       = 1'b1;
    excep_flag = 1'b1;
    repeat (2) @(negedge clk);
    eret       = 1'b0;
    excep_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (halt_out !== 1'b1 || pc_redirect !== 1'b0 || {id_flush, EX_FLUSH, MEM_FLUSH} !== 3'b000 ||
        epc !== 32'h0000_0040 || excep_count !== 2'd2) begin
      failures++;
      $display("[TB] FAIL halt_sticky: halt=%b redir=%b flush=%b%b%b epc=%h cnt=%0d expected 1 0 000 00000040 2",
               halt_out, pc_redirect, id_flush, EX_FLUSH, MEM_FLUSH, epc, excep_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enter_handler(32'h0000_0200, 7'h33);
    eret       = 1'b1;
    excep_flag = 1'b1;
    @(negedge clk);
    eret       = 1'b0;
    excep_flag = 1'b0;
    checks++;
    if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0000_0204 || halt_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eret_priority: redir=%b rpc=%h halt=%b expected 1 00000204 0", pc_redirect, redirect_pc, halt_out);
    end
    @(negedge clk);
    checks++;
    if (halt_out !== 1'b0 || in_handler !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eret_priority_idle: halt=%b ih=%b expected 0 0", halt_out, in_handler);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] expCount;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      enter_handler(32'(i * 16), 7'h01);
      eret = 1'b1;
      @(negedge clk);
      eret = 1'b0;
      @(negedge clk);
      expCount = (i > 3) ? 2'd3 : 2'(i);
      checks++;
      if (excep_count !== expCount) begin
        failures++;
        $display("[TB] FAIL count_trip%0d: got %0d expected %0d", i, excep_count, expCount);
      end
    end
  endtask

  task automatic test_wrap();
    enter_handler(32'hFFFF_FFFC, 7'h7F);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    checks++;
    if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0000_0000 || epc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("[TB] FAIL epc_wrap: redir=%b rpc=%h epc=%h expected 1 00000000 fffffffc", pc_redirect, redirect_pc, epc);
    end
    @(negedge clk);
  endtask

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    excep_flag = 1'b0;
    ID_PC      = '0;
    ID_opcode  = '0;
    eret       = 1'b0;
    test_reset();
    test_single_exception();
    test_return();
    test_nested_fault();
    test_simultaneous();
    test_saturation();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
